// File: rtl/mat_feed.sv
// mat_feed: operand feeder for the systolic matrix-multiply array.
// It buffers one NxN pair (A, B) received over a load handshake. It then
// streams A rows on the left edge and B columns on the top edge, with the
// systolic diagonal skew, over a valid/ready handshake. A one-cycle 'done'
// pulse follows the last accepted feed step.
// Optional feature macro: MAT_FEED_STALL_CNT_EN enables the feed stall counter;
// when undefined, stall_cnt is tied to zero.
module mat_feed #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            ld_vld,
  output logic            ld_rdy,
  input  logic [DW-1:0]   ld_a,
  input  logic [DW-1:0]   ld_b,
  output logic            vld_out,
  input  logic            rdy_in,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic            done,
  output logic [15:0]     stall_cnt
);

  localparam int NN = N * N;
  localparam int KW = $clog2(NN);
  localparam int TW = $clog2(2 * N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [KW-1:0]   k_r;
  logic [TW-1:0]   t_r;
  // High during every cycle that follows a reset edge. It keeps ld_rdy low
  // while rst is held, even though the state is already LOAD.
  logic            rst_hold_r;
  logic [DW-1:0]   a_mem_r [NN];
  logic [DW-1:0]   b_mem_r [NN];

  logic            ld_rdy_s;
  logic            vld_s;
  logic            done_s;
  logic            ld_acc_s;
  logic            step_acc_s;
  logic            last_beat_s;
  logic [N*DW-1:0] a_out_s;
  logic [N*DW-1:0] b_out_s;

  // Handshake flags decoded purely from registered state.
  always_comb begin
    ld_rdy_s = 1'b0;
    vld_s    = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_LOAD: ld_rdy_s = ~rst_hold_r;
      ST_FEED: vld_s    = 1'b1;
      ST_DONE: done_s   = 1'b1;
      default: begin
        ld_rdy_s = 1'b0;
        vld_s    = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  assign ld_acc_s    = ld_vld & ld_rdy_s;
  assign step_acc_s  = vld_s & rdy_in;
  assign last_beat_s = ld_acc_s & (k_r == K_LAST);

  // Sequencer: the load beat counter, the feed step counter and the state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r    <= ST_LOAD;
      k_r        <= '0;
      t_r        <= '0;
      rst_hold_r <= 1'b1;
    end else begin
      rst_hold_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (last_beat_s) begin
            state_r <= ST_FEED;
            k_r     <= '0;
            t_r     <= '0;
          end else if (ld_acc_s) begin
            k_r <= k_r + KW'(1);
          end else begin
            k_r <= k_r;
          end
        end
        ST_FEED: begin
          if (step_acc_s && (t_r == T_LAST)) begin
            state_r <= ST_DONE;
            t_r     <= '0;
          end else if (step_acc_s) begin
            t_r <= t_r + TW'(1);
          end else begin
            t_r <= t_r;
          end
        end
        ST_DONE: begin
          state_r <= ST_LOAD;
        end
        default: begin
          state_r <= ST_LOAD;
          k_r     <= '0;
          t_r     <= '0;
        end
      endcase
    end
  end

  // Operand buffers: each accepted beat is written row-major at index k.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int e = 0; e < NN; e++) begin
        a_mem_r[e] <= '0;
        b_mem_r[e] <= '0;
      end
    end else if (ld_acc_s) begin
      a_mem_r[k_r] <= ld_a;
      b_mem_r[k_r] <= ld_b;
    end else begin
      for (int e = 0; e < NN; e++) begin
        a_mem_r[e] <= a_mem_r[e];
        b_mem_r[e] <= b_mem_r[e];
      end
    end
  end

  // Skewed edge vectors: lane i carries element (t-i) of its row/column, or 0.
  always_comb begin
    int            d;
    logic [KW-1:0] ia;
    logic [KW-1:0] ib;
    d       = 0;
    ia      = '0;
    ib      = '0;
    a_out_s = '0;
    b_out_s = '0;
    if (state_r == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        d = int'(t_r) - i;
        if ((d >= 0) && (d < N)) begin
          ia = KW'(i * N + d);
          ib = KW'(d * N + i);
          a_out_s[i*DW +: DW] = a_mem_r[ia];
          b_out_s[i*DW +: DW] = b_mem_r[ib];
        end else begin
          a_out_s[i*DW +: DW] = '0;
          b_out_s[i*DW +: DW] = '0;
        end
      end
    end else begin
      a_out_s = '0;
      b_out_s = '0;
    end
  end

  assign ld_rdy  = ld_rdy_s;
  assign vld_out = vld_s;
  assign done    = done_s;
  assign a_out   = a_out_s;
  assign b_out   = b_out_s;

`ifdef MAT_FEED_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Stall counter: restarts on FEED entry, counts refused steps and saturates.
  always_ff @(posedge CLK) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (last_beat_s) begin
      stall_cnt_r <= 16'h0000;
    end else if (vld_s && !rdy_in && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
